// File: rtl/noaa_pkg.sv
// Shared widths and mode encodings for the mote statistics engine.
package noaa_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned W      = 12;
  localparam int unsigned LOG2N  = $clog2(N);
  localparam int unsigned SUM_W  = W + LOG2N;
  localparam int unsigned SQ_W   = 2 * W + LOG2N;
  localparam int unsigned SQIN_W = 2 * W;
  localparam int unsigned VAR_W  = 2 * SUM_W;
  localparam int unsigned CNT_W  = $clog2(N + 1);

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_SD  = 1'b1;

endpackage

// File: rtl/noaa_isqrt.sv
// Combinational restoring integer square root: floor(sqrt(rad_i)).
module noaa_isqrt
  import noaa_pkg::*;
(
  input  logic [SQIN_W-1:0] rad_i,
  output logic [W-1:0]      root_o
);

  logic [W+1:0] rem;
  logic [W+1:0] trial;
  logic [W-1:0] root;

  // One result bit per iteration, radicand consumed two bits at a time from the top.
  always_comb begin
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      rem   = {rem[W-1:0], rad_i[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[W-2:0], 1'b1};
      end else begin
        root = {root[W-2:0], 1'b0};
      end
    end
    root_o = root;
  end

endmodule

// File: rtl/noaa_mote_stats.sv
// Sliding-window mean / standard deviation over the last N temperature samples.
module noaa_mote_stats
  import noaa_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MODE,
  input  logic [W-1:0] TN,
  output logic         SAMPLE,
  output logic         DONE,
  output logic [W-1:0] AVG_SD
);

  logic [W-1:0]       win_q [N];
  logic [LOG2N-1:0]   ptr_q;
  logic [SUM_W-1:0]   sum_q,   sum_d;
  logic [SQ_W-1:0]    sumsq_q, sumsq_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               mode_q;
  logic               sample_q;
  logic               done_q,  done_d;
  logic [W-1:0]       avg_q,   avg_d;

  logic [W-1:0]       evicted;
  logic [SQIN_W-1:0]  tn_sq;
  logic [SQIN_W-1:0]  ev_sq;
  logic [W-1:0]       mean;
  logic [VAR_W-1:0]   n_sumsq;
  logic [VAR_W-1:0]   sum_sq;
  logic [VAR_W-1:0]   var_scaled;
  logic [SQIN_W-1:0]  var_int;
  logic [W-1:0]       sd;

  // Capture stage: running sums updated by adding the new sample and removing the evicted one.
  always_comb begin
    evicted = win_q[ptr_q];
    tn_sq   = SQIN_W'(TN) * SQIN_W'(TN);
    ev_sq   = SQIN_W'(evicted) * SQIN_W'(evicted);
    sum_d   = sum_q + SUM_W'(TN) - SUM_W'(evicted);
    sumsq_d = sumsq_q + SQ_W'(tn_sq) - SQ_W'(ev_sq);
    cnt_d   = (cnt_q == CNT_W'(N)) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Output stage: exact variance as (N*SUMSQ - SUM^2) / N^2, which is never negative.
  always_comb begin
    mean       = W'(sum_q >> LOG2N);
    n_sumsq    = {sumsq_q, {LOG2N{1'b0}}};
    sum_sq     = VAR_W'(sum_q) * VAR_W'(sum_q);
    var_scaled = (n_sumsq >= sum_sq) ? (n_sumsq - sum_sq) : '0;
    var_int    = SQIN_W'(var_scaled >> (2 * LOG2N));
    avg_d      = (mode_q == MODE_SD) ? sd : mean;
    done_d     = (cnt_q == CNT_W'(N));
  end

  noaa_isqrt u_isqrt (
    .rad_i  (var_int),
    .root_o (sd)
  );

  // Window, sums, fill counter and result registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(N); i++) begin
        win_q[i] <= '0;
      end
      ptr_q    <= '0;
      sum_q    <= '0;
      sumsq_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_AVG;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      avg_q    <= '0;
    end else begin
      win_q[ptr_q] <= TN;
      ptr_q        <= ptr_q + LOG2N'(1);
      sum_q        <= sum_d;
      sumsq_q      <= sumsq_d;
      cnt_q        <= cnt_d;
      mode_q       <= MODE;
      sample_q     <= 1'b1;
      done_q       <= done_d;
      avg_q        <= avg_d;
    end
  end

  assign SAMPLE = sample_q;
  assign DONE   = done_q;
  assign AVG_SD = avg_q;

endmodule

// File: tb/tb_noaa_mote_stats.sv
// Directed and reference-model checks for the mote statistics engine.
module tb_noaa_mote_stats;

  typedef struct {
    logic [11:0] tn;
    logic        mode;
    int          exp;
    logic        exp_done;
    bit          chk;
    int          tol;
  } vec_t;

  logic        CLK;
  logic        RESET;
  logic        MODE;
  logic [11:0] TN;
  logic        SAMPLE;
  logic        DONE;
  logic [11:0] AVG_SD;

  int tests_run;
  int tests_failed;

  vec_t vq[$];

  int mwin [8];
  int mptr;
  int mcnt;

  noaa_mote_stats dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .MODE   (MODE),
    .TN     (TN),
    .SAMPLE (SAMPLE),
    .DONE   (DONE),
    .AVG_SD (AVG_SD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void add(int tn, logic mode, int exp, logic exp_done, bit chk, int tol);
    vec_t v;
    v.tn       = 12'(tn);
    v.mode     = mode;
    v.exp      = exp;
    v.exp_done = exp_done;
    v.chk      = chk;
    v.tol      = tol;
    vq.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mwin[i] = 0;
    mptr = 0;
    mcnt = 0;
  endfunction

  function automatic void model_push(int tn);
    mwin[mptr] = tn;
    mptr = (mptr + 1) % 8;
    if (mcnt < 8) mcnt++;
  endfunction

  function automatic int model_exp(logic mode);
    real s, sq, m, v;
    s  = 0.0;
    sq = 0.0;
    for (int i = 0; i < 8; i++) begin
      s  = s + real'(mwin[i]);
      sq = sq + real'(mwin[i]) * real'(mwin[i]);
    end
    m = s / 8.0;
    v = sq / 8.0 - m * m;
    if (v < 0.0) v = 0.0;
    if (mode) return int'($floor($sqrt(v)));
    return int'($floor(m));
  endfunction

  task automatic check_int(string name, int act, int exp, int tol);
    int d;
    tests_run++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_vec(int idx);
    check_int($sformatf("done[%0d]", idx), int'(DONE), int'(vq[idx].exp_done), 0);
    check_int($sformatf("sample[%0d]", idx), int'(SAMPLE), 1, 0);
    if (vq[idx].chk)
      check_int($sformatf("avg_sd[%0d]", idx), int'(AVG_SD), vq[idx].exp, vq[idx].tol);
  endtask

  // Called at a falling edge; the result for vector j is visible two falling edges later.
  task automatic run_vectors();
    for (int j = 0; j < vq.size() + 2; j++) begin
      if (j >= 2) check_vec(j - 2);
      if (j < vq.size()) begin
        TN   = vq[j].tn;
        MODE = vq[j].mode;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    int tn;
    logic md;
    tests_run    = 0;
    tests_failed = 0;
    RESET = 1'b0;
    TN    = '0;
    MODE  = 1'b0;
    model_reset();

    #3;
    check_int("reset_avg",    int'(AVG_SD), 0, 0);
    check_int("reset_done",   int'(DONE),   0, 0);
    check_int("reset_sample", int'(SAMPLE), 0, 0);

    // Fill, constant SD, alternating pattern, slide, extremes.
    for (int i = 0; i < 8; i++) add(100, 1'b0, 100, (i == 7), (i == 7), 0);
    for (int i = 0; i < 8; i++) add(100, 1'b1, 0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) add((i % 2) ? 200 : 0, 1'b1, 100, 1'b1, (i == 7), 0);
    for (int i = 0; i < 8; i++) add((i % 2) ? 200 : 0, 1'b0, 100, 1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) add(100, 1'b0, 100, 1'b1, (i == 7), 0);
    for (int k = 1; k <= 8; k++) add(300, 1'b0, 100 + 25 * k, 1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) add(4095, 1'b0, 4095, 1'b1, (i == 7), 0);
    for (int i = 0; i < 8; i++) add(4095, 1'b1, 0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) add((i % 2) ? 4095 : 0, 1'b1, 2047, 1'b1, (i == 7), 0);

    @(negedge CLK);
    RESET = 1'b1;
    run_vectors();

    // Mid-run asynchronous reset.
    check_int("pre_reset_done", int'(DONE), 1, 0);
    #2;
    RESET = 1'b0;
    #1;
    check_int("midreset_avg",    int'(AVG_SD), 0, 0);
    check_int("midreset_done",   int'(DONE),   0, 0);
    check_int("midreset_sample", int'(SAMPLE), 0, 0);
    @(negedge CLK);

    vq.delete();
    model_reset();
    for (int i = 0; i < 8; i++) begin
      model_push(50);
      add(50, 1'b0, 50, (i == 7), (i == 7), 0);
    end
    for (int i = 0; i < 200; i++) begin
      tn = int'($urandom_range(0, 4095));
      md = 1'($urandom_range(0, 1));
      model_push(tn);
      add(tn, md, model_exp(md), (mcnt >= 8), 1'b1, 3);
    end

    RESET = 1'b1;
    run_vectors();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
